// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_if
//  Brief    : Request/response bundle between the core and data_mem_unit.
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        misalign;

  // Core side: issues the request and holds it until ready.
  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, stall, misalign
  );

  // Memory side.
  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, stall, misalign
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_unit
//  Brief    : Byte/half/word data memory with programmable wait states and a
//             combinational stall for the single-cycle MIPS32 core.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
  localparam int         c_WAIT_M1   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] c_WAIT_LOAD = 4'(c_WAIT_M1);
  localparam bit         c_NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;

  // Captured request; only the address bits that select a word/lane are kept.
  logic               r_we;
  logic               r_sext;
  logic [1:0]         r_size;
  logic [c_IDX_W+1:0] r_addr;
  logic [31:0]        r_wdata;

  logic [31:0] r_rdata;
  logic        r_misalign;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic w_idle;
  logic w_fault;
  logic w_capture;
  logic w_access;
  logic w_fault_done;
  logic w_mem_wr;

  // Operands of the access actually being performed this edge.
  logic               w_a_we;
  logic               w_a_sext;
  logic [1:0]         w_a_size;
  logic [c_IDX_W+1:0] w_a_addr;
  logic [31:0]        w_a_wdata;
  logic [c_IDX_W-1:0] w_idx;
  logic [1:0]         w_lane;
  logic [31:0]        w_word;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [3:0]         w_bmask;
  logic [31:0]        w_bdata;
  logic [31:0]        w_merged;

  // Address bits above the array are deliberately ignored (wrap-around).
  logic w_unused_addr;
  assign w_unused_addr = ^bus.addr[31:c_IDX_W+2];

  assign w_idle = (r_state == ST_IDLE);

  // Size/alignment fault is judged on the live request at the accept edge.
  assign w_fault = (bus.size == 2'b11)
                 | ((bus.size == 2'b01) & bus.addr[0])
                 | ((bus.size == 2'b10) & (bus.addr[1:0] != 2'b00));

  // A zero-wait access happens on the accept edge, so it must use the live
  // inputs; a waited access uses the copy captured at acceptance.
  assign w_a_we    = w_idle ? bus.we                 : r_we;
  assign w_a_sext  = w_idle ? bus.sign_ext           : r_sext;
  assign w_a_size  = w_idle ? bus.size               : r_size;
  assign w_a_addr  = w_idle ? bus.addr[c_IDX_W+1:0]  : r_addr;
  assign w_a_wdata = w_idle ? bus.wdata              : r_wdata;

  assign w_idx  = w_a_addr[c_IDX_W+1:2];
  assign w_lane = w_a_addr[1:0];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Gate with rst_n so a request seen while reset is held never writes.
  assign w_mem_wr = w_access & w_a_we & rst_n;

  assign bus.stall    = (w_idle & bus.req) | (r_state == ST_WAIT);
  assign bus.ready    = (r_state == ST_DONE);
  assign bus.rdata    = r_rdata;
  assign bus.misalign = r_misalign;

  // Next-state and access/capture strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_access     = 1'b0;
    w_fault_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_capture = 1'b1;
          if (w_fault) begin
            w_fault_done = 1'b1;
            w_state_nxt  = ST_DONE;
          end else if (c_NO_WAIT) begin
            w_access    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt   = c_WAIT_LOAD;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Load extraction and extension; word loads pass straight through.
  always_comb begin
    w_load = w_word;
    case (w_a_size)
      2'b00:   w_load = {{24{w_a_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{w_a_sext & w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Store lane merge: replicate the data across lanes, enable only addressed bytes.
  always_comb begin
    w_bmask = 4'b0000;
    w_bdata = 32'h0;
    case (w_a_size)
      2'b00: begin
        w_bmask = 4'b0001 << w_lane;
        w_bdata = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_bmask = w_lane[1] ? 4'b1100 : 4'b0011;
        w_bdata = {2{w_a_wdata[15:0]}};
      end
      default: begin
        w_bmask = 4'b1111;
        w_bdata = w_a_wdata;
      end
    endcase
    w_merged = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_bmask[i]) w_merged[8*i +: 8] = w_bdata[8*i +: 8];
    end
  end

  // State and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else if (w_capture) begin
      r_we    <= bus.we;
      r_sext  <= bus.sign_ext;
      r_size  <= bus.size;
      r_addr  <= bus.addr[c_IDX_W+1:0];
      r_wdata <= bus.wdata;
    end
  end

  // Response registers, presented while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata    <= 32'h0;
      r_misalign <= 1'b0;
    end else if (w_fault_done) begin
      r_rdata    <= 32'h0;
      r_misalign <= 1'b1;
    end else if (w_access) begin
      r_rdata    <= w_a_we ? 32'h0 : w_load;
      r_misalign <= 1'b0;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[w_idx] <= w_merged;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_unit
//  Brief    : Scoreboard bench for data_mem_unit: a 2-wait-state instance
//             driven with directed and random traffic, plus a zero-wait
//             instance for back-to-back latency and wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_unit;

  localparam int c_DEPTH0 = 256;
  localparam int c_WAIT0  = 2;
  localparam int c_DEPTH1 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus0 ();
  data_mem_if bus1 ();

  data_mem_unit #(.DEPTH_WORDS(c_DEPTH0), .WAIT_CYCLES(c_WAIT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  data_mem_unit #(.DEPTH_WORDS(c_DEPTH1), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [c_DEPTH0];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req_v);
    end
  endfunction

  // Reference model: compute the response and update memory from the rules.
  function automatic exp_t model(input logic w, input logic [1:0] sz,
                                 input logic se, input logic [31:0] a,
                                 input logic [31:0] wd);
    exp_t        e;
    int          idx;
    int          lane;
    bit          f;
    logic [31:0] mask;
    logic [31:0] v;
    idx  = int'((a >> 2) % c_DEPTH0);
    lane = int'(a % 4);
    f    = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    e.misalign = f;
    e.lat      = f ? 1 : c_WAIT0 + 1;
    e.rdata    = 32'h0;
    if (!f) begin
      if (w) begin
        mdl[idx] = (mdl[idx] & ~(mask << (8*lane))) | ((wd & mask) << (8*lane));
      end else begin
        v = (mdl[idx] >> (8*lane)) & mask;
        if (se && sz != 2'd2 && (v & ((mask >> 1) + 1)) != 0) v = v | ~mask;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Drive one request on bus0; inputs are scrambled after the accept edge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic se,
                       input logic [31:0] a, input logic [31:0] wd);
    int t;
    q.push_back(model(w, sz, se, a, wd));
    @(posedge clk); #1;
    bus0.we = w; bus0.size = sz; bus0.sign_ext = se; bus0.addr = a; bus0.wdata = wd;
    bus0.req = 1'b1;
    @(posedge clk); #1;
    bus0.we = 1'($urandom); bus0.size = 2'($urandom); bus0.sign_ext = 1'($urandom);
    bus0.addr = $urandom; bus0.wdata = $urandom;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus0.ready && t < 40);
    if (!bus0.ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no ready after %0d cycles, required within %0d", t, c_WAIT0 + 2);
      q.delete();
    end
    @(posedge clk); #1;
    bus0.req = 1'b0;
  endtask

  // Monitor: counts stall cycles and checks each completion against the queue.
  int   stall_cnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
    end else if (bus0.ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: actual=1 required=0");
      end else begin
        me = q.pop_front();
        check("rdata",    bus0.rdata,           me.rdata);
        check("misalign", 32'(bus0.misalign),   32'(me.misalign));
        check("latency",  32'(stall_cnt),       32'(me.lat));
        check("stall_in_done", 32'(bus0.stall), 32'd0);
      end
      stall_cnt = 0;
    end else if (bus0.stall) begin
      stall_cnt++;
    end
  end

  // Zero-wait instance: request held high across accesses; checks each phase.
  task automatic op1(input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd);
    @(posedge clk); #1;
    bus1.we = w; bus1.size = 2'b10; bus1.sign_ext = 1'b0; bus1.addr = a; bus1.wdata = wd;
    bus1.req = 1'b1;
    @(negedge clk);
    check("b2b_stall",       32'(bus1.stall), 32'd1);
    check("b2b_ready_early", 32'(bus1.ready), 32'd0);
    @(negedge clk);
    check("b2b_ready",       32'(bus1.ready), 32'd1);
    check("b2b_stall_done",  32'(bus1.stall), 32'd0);
    check("b2b_rdata",       bus1.rdata,      exp_rd);
    check("b2b_misalign",    32'(bus1.misalign), 32'd0);
  endtask

  initial begin
    bus0.req = 0; bus0.we = 0; bus0.size = 0; bus0.sign_ext = 0; bus0.addr = 0; bus0.wdata = 0;
    bus1.req = 0; bus1.we = 0; bus1.size = 0; bus1.sign_ext = 0; bus1.addr = 0; bus1.wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",    32'(bus0.ready),    32'd0);
    check("rst_rdata",    bus0.rdata,         32'd0);
    check("rst_misalign", 32'(bus0.misalign), 32'd0);
    check("rst_stall",    32'(bus0.stall),    32'd0);
    rst_n = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < c_DEPTH0; i++) issue(1'b1, 2'b10, 1'b0, 32'(i * 4), $urandom);

    // Directed sequence.
    issue(1'b1, 2'b10, 1'b0, 32'h10,  32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10,  32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h11,  32'h0000_00AA);
    issue(1'b0, 2'b10, 1'b0, 32'h10,  32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h11,  32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h11,  32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h12,  32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h12,  32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h12,  32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h13,  32'h0000_5555);
    issue(1'b0, 2'b10, 1'b0, 32'h10,  32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0,   32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0,   32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20,  32'h0);

    // Store aborted by reset while waiting; outputs clear immediately.
    @(posedge clk); #1;
    bus0.we = 1'b1; bus0.size = 2'b10; bus0.sign_ext = 1'b0;
    bus0.addr = 32'h20; bus0.wdata = 32'h1234_5678; bus0.req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus0.req = 1'b0;
    #1;
    check("abort_ready",    32'(bus0.ready),    32'd0);
    check("abort_rdata",    bus0.rdata,         32'd0);
    check("abort_misalign", 32'(bus0.misalign), 32'd0);
    check("abort_stall",    32'(bus0.stall),    32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    // Zero-wait instance: back-to-back word accesses and wrap at 16 words.
    op1(1'b1, 32'h0,  32'hCAFE_F00D, 32'h0);
    op1(1'b1, 32'h4,  32'h0BAD_BEEF, 32'h0);
    op1(1'b0, 32'h0,  32'h0,         32'hCAFE_F00D);
    op1(1'b0, 32'h40, 32'h0,         32'hCAFE_F00D);
    op1(1'b0, 32'h44, 32'h0,         32'h0BAD_BEEF);
    @(posedge clk); #1;
    bus1.req = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
